sargantana_itag_lookup: RTL and testbench

//  Next-generation I-cache tag array: per-way tag + valid storage with integrated tag compare,
//  one-hot hit vector, optional per-tag parity and a multi-cycle invalidation sweep FSM.

---
 rtl/sargantana_itag_lookup.sv | 140 ++++++++++++++
 tb/tb_sargantana_itag_lookup.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sargantana_itag_lookup.sv
// I-cache tag array: per-way tag/valid/parity storage with registered read, tag compare,
// one-hot hit vector and a set-by-set invalidation sweep that replaces a reset of the valid bits.
module sargantana_itag_lookup #(
  parameter int unsigned ICACHE_N_WAY   = 4,
  parameter int unsigned TAG_DEPTH      = 64,
  parameter int unsigned TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
  parameter int unsigned TAG_WIDHT      = 20,
  parameter bit          PARITY_EN      = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic [ICACHE_N_WAY-1:0]           req_i,
  input  logic                              we_i,
  input  logic                              vbit_i,
  input  logic [TAG_WIDHT-1:0]              data_i,
  input  logic                              parity_flip_i,
  input  logic [TAG_ADDR_WIDHT-1:0]         addr_i,
  input  logic [TAG_WIDHT-1:0]              cmp_tag_i,
  input  logic                              flush_i,
  output logic                              ready_o,
  output logic [ICACHE_N_WAY*TAG_WIDHT-1:0] tag_way_o,
  output logic [ICACHE_N_WAY-1:0]           vbit_o,
  output logic [ICACHE_N_WAY-1:0]           hit_way_o,
  output logic                              hit_o,
  output logic [ICACHE_N_WAY-1:0]           perr_o
);

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  localparam logic [TAG_ADDR_WIDHT-1:0] LAST_SET = TAG_ADDR_WIDHT'(TAG_DEPTH - 1);

  state_e                    state_q, state_d;
  logic [TAG_ADDR_WIDHT-1:0] cnt_q, cnt_d;

  logic [TAG_WIDHT-1:0] tag_mem [ICACHE_N_WAY][TAG_DEPTH];
  logic                 vld_mem [ICACHE_N_WAY][TAG_DEPTH];
  logic                 par_mem [ICACHE_N_WAY][TAG_DEPTH];

  logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0] tag_q;
  logic [ICACHE_N_WAY-1:0]                vbit_q;
  logic [ICACHE_N_WAY-1:0]                par_q;
  logic [TAG_WIDHT-1:0]                   cmp_tag_q;

  logic                    idle, access, wr_en, rd_en, sweeping;
  logic [ICACHE_N_WAY-1:0] perr, hit;

  assign idle     = (state_q == S_IDLE);
  assign sweeping = (state_q == S_FLUSH);
  // A flush request pre-empts any access presented in the same cycle.
  assign access   = idle & ~flush_i;
  assign wr_en    = access & we_i;
  assign rd_en    = access & ~we_i & (|req_i);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      S_FLUSH: begin
        if (cnt_q == LAST_SET) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_FLUSH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_FLUSH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the storage arrays have no reset so they map onto plain memory; the sweep clears valids.
  always_ff @(posedge clk_i) begin
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      if (sweeping) begin
        vld_mem[w][cnt_q] <= 1'b0;
      end else if (wr_en && req_i[w]) begin
        tag_mem[w][addr_i] <= data_i;
        vld_mem[w][addr_i] <= vbit_i;
        par_mem[w][addr_i] <= (^data_i) ^ parity_flip_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tag_q     <= '0;
      vbit_q    <= '0;
      par_q     <= '0;
      cmp_tag_q <= '0;
    end else if (sweeping) begin
      vbit_q <= '0;
    end else if (rd_en) begin
      cmp_tag_q <= cmp_tag_i;
      for (int w = 0; w < ICACHE_N_WAY; w++) begin
        if (req_i[w]) begin
          tag_q[w]  <= tag_mem[w][addr_i];
          vbit_q[w] <= vld_mem[w][addr_i];
          par_q[w]  <= par_mem[w][addr_i];
        end else begin
          vbit_q[w] <= 1'b0;
        end
      end
    end
  end

  // A parity error turns a would-be hit into a miss.
  always_comb begin
    perr = '0;
    hit  = '0;
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      perr[w] = PARITY_EN & vbit_q[w] & (par_q[w] ^ (^tag_q[w]));
      hit[w]  = vbit_q[w] & (tag_q[w] == cmp_tag_q) & ~perr[w];
    end
  end

  assign ready_o   = idle;
  assign tag_way_o = tag_q;
  assign vbit_o    = idle ? vbit_q : '0;
  assign hit_way_o = idle ? hit    : '0;
  assign perr_o    = idle ? perr   : '0;
  assign hit_o     = |hit_way_o;

endmodule

// File: tb/tb_sargantana_itag_lookup.sv
// Self-checking bench for sargantana_itag_lookup: directed scenarios followed by random
// traffic, compared against an array-based model of the tag store.
module tb_sargantana_itag_lookup;

  localparam int NW = 4;
  localparam int D  = 64;
  localparam int AW = 6;
  localparam int TW = 20;

  logic               clk_i = 1'b0;
  logic               rstn_i = 1'b0;
  logic [NW-1:0]      req_i = '0;
  logic               we_i = 1'b0;
  logic               vbit_i = 1'b0;
  logic [TW-1:0]      data_i = '0;
  logic               parity_flip_i = 1'b0;
  logic [AW-1:0]      addr_i = '0;
  logic [TW-1:0]      cmp_tag_i = '0;
  logic               flush_i = 1'b0;
  logic               ready_o;
  logic [NW*TW-1:0]   tag_way_o;
  logic [NW-1:0]      vbit_o, hit_way_o, perr_o;
  logic               hit_o;

  sargantana_itag_lookup #(
    .ICACHE_N_WAY(NW), .TAG_DEPTH(D), .TAG_WIDHT(TW), .PARITY_EN(1'b1)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .we_i(we_i), .vbit_i(vbit_i),
    .data_i(data_i), .parity_flip_i(parity_flip_i), .addr_i(addr_i), .cmp_tag_i(cmp_tag_i),
    .flush_i(flush_i), .ready_o(ready_o), .tag_way_o(tag_way_o), .vbit_o(vbit_o),
    .hit_way_o(hit_way_o), .hit_o(hit_o), .perr_o(perr_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Model of the stored array contents.
  logic [TW-1:0] m_tag  [NW][D];
  bit            m_vld  [NW][D];
  bit            m_par  [NW][D];
  bit            m_init [NW][D];

  // Model of the registered read outputs.
  logic [TW-1:0] e_tag   [NW];
  bit            e_v     [NW];
  bit            e_par   [NW];
  bit            e_known [NW];
  logic [TW-1:0] e_cmp;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req_i = '0; we_i = 1'b0; vbit_i = 1'b0; data_i = '0; parity_flip_i = 1'b0;
    addr_i = '0; cmp_tag_i = '0; flush_i = 1'b0;
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      e_tag[w] = '0; e_v[w] = 1'b0; e_par[w] = 1'b0; e_known[w] = 1'b1;
    end
    e_cmp = '0;
  endtask

  task automatic model_flush();
    for (int w = 0; w < NW; w++) begin
      e_v[w] = 1'b0;
      for (int s = 0; s < D; s++) m_vld[w][s] = 1'b0;
    end
  endtask

  task automatic check_outputs(input string name);
    logic [NW-1:0] ev, eperr, ehit;
    for (int w = 0; w < NW; w++) begin
      ev[w]    = e_v[w];
      eperr[w] = e_v[w] && (e_par[w] != (^e_tag[w]));
      ehit[w]  = e_v[w] && (e_tag[w] == e_cmp) && !eperr[w];
    end
    check({name, ".ready"}, ready_o, 1);
    check({name, ".vbit"}, vbit_o, ev);
    check({name, ".perr"}, perr_o, eperr);
    check({name, ".hit_way"}, hit_way_o, ehit);
    check({name, ".hit"}, hit_o, |ehit);
    for (int w = 0; w < NW; w++)
      if (e_known[w]) check({name, ".tag"}, tag_way_o[w*TW +: TW], e_tag[w]);
  endtask

  // Called at the first negedge where the sweep is running; counts ready_o-low cycles.
  task automatic wait_sweep(input string name, input int inject_at);
    int low = 0;
    while (ready_o !== 1'b1 && low < 200) begin
      check({name, ".sweep_quiet"}, {vbit_o, hit_way_o, perr_o, hit_o}, 0);
      if (low == inject_at) begin
        flush_i = 1'b1; req_i = '1; we_i = 1'b1; data_i = 20'hFFFFF; addr_i = 5;
      end else begin
        idle_inputs();
      end
      low++;
      @(negedge clk_i);
    end
    idle_inputs();
    check({name, ".sweep_len"}, low, D);
  endtask

  task automatic do_write(input logic [NW-1:0] mask, input int s, input logic [TW-1:0] tag,
                          input bit v, input bit flip);
    req_i = mask; we_i = 1'b1; addr_i = AW'(s); data_i = tag; vbit_i = v; parity_flip_i = flip;
    @(negedge clk_i);
    idle_inputs();
    for (int w = 0; w < NW; w++) begin
      if (mask[w]) begin
        m_tag[w][s] = tag; m_vld[w][s] = v; m_par[w][s] = (^tag) ^ flip; m_init[w][s] = 1'b1;
      end
    end
    check_outputs("write");
  endtask

  task automatic do_read(input string name, input logic [NW-1:0] mask, input int s,
                         input logic [TW-1:0] cmp);
    req_i = mask; we_i = 1'b0; addr_i = AW'(s); cmp_tag_i = cmp;
    @(negedge clk_i);
    idle_inputs();
    if (mask != '0) begin
      e_cmp = cmp;
      for (int w = 0; w < NW; w++) begin
        if (mask[w]) begin
          e_tag[w] = m_tag[w][s]; e_v[w] = m_vld[w][s]; e_par[w] = m_par[w][s];
          e_known[w] = m_init[w][s];
        end else begin
          e_v[w] = 1'b0;
        end
      end
    end
    check_outputs(name);
  endtask

  task automatic start_flush(input logic [NW-1:0] mask);
    flush_i = 1'b1; req_i = mask; we_i = 1'b1; data_i = 20'hFFFFF; addr_i = 5; vbit_i = 1'b1;
    @(negedge clk_i);
    idle_inputs();
    model_flush();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < D; s++) begin
        m_tag[w][s] = '0; m_vld[w][s] = 1'b0; m_par[w][s] = 1'b0; m_init[w][s] = 1'b0;
      end
    model_reset();
    idle_inputs();

    // 1: reset state, sweep length, every set reads invalid.
    repeat (3) @(negedge clk_i);
    check("reset.ready", ready_o, 0);
    check("reset.outs", {tag_way_o, vbit_o, hit_way_o, hit_o, perr_o}, 0);
    rstn_i = 1'b1;
    wait_sweep("reset", -1);
    for (int s = 0; s < D; s++) do_read("init_read", '1, s, TW'($urandom));

    // Give every entry a known tag so later held tag outputs are predictable.
    for (int s = 0; s < D; s++) do_write('1, s, TW'($urandom), 1'b0, 1'b0);

    // 2, 3: write way2 set5, then hit and near-miss compares.
    do_write(4'b0100, 5, 20'h12345, 1'b1, 1'b0);
    do_read("hit_way2", 4'b0100, 5, 20'h12345);
    check("hit_way2.onehot", hit_way_o, 4'b0100);
    do_read("miss_way2", 4'b0100, 5, 20'h12344);
    check("miss_way2.hit", hit_o, 0);

    // 5: injected parity error reads as a miss.
    do_write(4'b0010, 9, 20'h0000F, 1'b1, 1'b1);
    do_read("perr_way1", 4'b0010, 9, 20'h0000F);
    check("perr_way1.perr", perr_o, 4'b0010);

    // Duplicate tags across ways all report a hit.
    do_write(4'b1011, 12, 20'hABCDE, 1'b1, 1'b0);
    do_read("multi_hit", '1, 12, 20'hABCDE);

    // 4: flush beats a same-cycle write; a second flush mid-sweep is ignored.
    start_flush('1);
    wait_sweep("flush", 10);
    do_read("post_flush", '1, 5, 20'h12345);
    do_read("post_flush12", '1, 12, 20'hABCDE);

    // 6: reset during the sweep clears outputs at once and restarts the sweep.
    do_read("pre_rst", 4'b0100, 5, 20'h12345);
    start_flush('0);
    repeat (30) @(negedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    model_reset();
    check("rst_mid.outs", {tag_way_o, vbit_o, hit_way_o, hit_o, perr_o, ready_o}, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    wait_sweep("rst_mid", -1);
    do_read("post_rst", '1, 5, 20'h12345);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      int op, s;
      logic [NW-1:0] mask;
      op   = int'($urandom_range(0, 39));
      s    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, D - 1)) : int'($urandom_range(0, 7));
      mask = NW'($urandom);
      if (op == 0) begin
        start_flush(mask);
        wait_sweep("rnd_flush", -1);
        check_outputs("rnd_post_flush");
      end else if (op < 18) begin
        do_write(mask, s, 20'hA0000 | TW'($urandom_range(0, 3)), bit'($urandom_range(0, 3) != 0),
                 bit'($urandom_range(0, 7) == 0));
      end else begin
        do_read("rnd_read", mask, s, 20'hA0000 | TW'($urandom_range(0, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
